// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
//   kp_state_t    : scanner FSM states
//   frame_class_t : classification of one full-matrix frame
//   key_legend()  : key index (4*row + col) to hex code, Pmod KYPD layout
//   classify_frame(), lowest_key() : frame image helpers
package keypad_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_PRESENT, ST_RELEASE} kp_state_t;
  typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_class_t;

  // Packed so entry [k] is the code for key index k.
  //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: 0 F E D
  localparam logic [15:0][3:0] KEY_LEGEND = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_legend(input logic [3:0] idx);
    return KEY_LEGEND[idx];
  endfunction

  function automatic frame_class_t classify_frame(input logic [15:0] img);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n += 5'(img[i]);
    if (n == 5'd0)      return FR_NONE;
    else if (n == 5'd1) return FR_SINGLE;
    else                return FR_MULTI;
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic logic [3:0] lowest_key(input logic [15:0] img);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (img[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Column dwell timer: free-running counter 0..SCAN_TICK_CYCLES-1 that asserts
// tick for one clock when it reaches its last value.
//   clock, reset_n : system clock, async active-low reset
//   tick           : one-cycle enable, once every SCAN_TICK_CYCLES clocks
module scan_tick_gen #(
  parameter int SCAN_TICK_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (SCAN_TICK_CYCLES > 1) ? $clog2(SCAN_TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner. Drives one column low at a time, samples the
// rows at the end of each column dwell, builds a 16-bit frame image, and
// debounces single-key frames into one key code per press.
//   clock, reset_n : system clock, async active-low reset
//   col            : column drive, active low, exactly one bit low
//   row            : row sense, active low, asynchronous
//   key_code/key_valid/key_ready : valid/ready output of accepted keys
//   multi_key      : last completed frame had two or more keys down
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICK_CYCLES = 100000,
  parameter int DEBOUNCE_SCANS   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       multi_key
);

  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  logic [3:0]   row_meta, row_sync;
  logic         tick, frame_end;
  logic [1:0]   col_idx;
  logic [15:0]  image, image_nxt;
  frame_class_t fclass;
  logic [3:0]   fkey;

  kp_state_t    state, state_nxt;
  logic [3:0]   cnt, cnt_nxt, cand, cand_nxt, code_nxt;
  logic         valid_nxt;

  // Rows idle high (pull-ups), so the synchroniser resets to "no key".
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  scan_tick_gen #(.SCAN_TICK_CYCLES(SCAN_TICK_CYCLES)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign col = ~(4'b0001 << col_idx);

  // Image bit {row,col} = key index 4*row+col. The frame is classified on the
  // image including the column being stored this tick.
  always_comb begin
    image_nxt = image;
    for (int r = 0; r < 4; r++) image_nxt[{r[1:0], col_idx}] = ~row_sync[r];
  end

  assign frame_end = tick && (col_idx == 2'd3);
  assign fclass    = classify_frame(image_nxt);
  assign fkey      = lowest_key(image_nxt);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_idx   <= 2'd0;
      image     <= '0;
      multi_key <= 1'b0;
    end else if (tick) begin
      col_idx <= col_idx + 2'd1;
      image   <= image_nxt;
      if (frame_end) multi_key <= (fclass == FR_MULTI);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cand      <= cand_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    code_nxt  = key_code;
    valid_nxt = key_valid;
    case (state)
      ST_IDLE: begin
        if (frame_end && fclass == FR_SINGLE) begin
          cand_nxt = fkey;
          cnt_nxt  = 4'd1;
          if (DS == 4'd1) begin
            state_nxt = ST_PRESENT;
            code_nxt  = key_legend(fkey);
            valid_nxt = 1'b1;
          end else begin
            state_nxt = ST_DEBOUNCE;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (frame_end) begin
          if (fclass == FR_SINGLE && fkey == cand) begin
            cnt_nxt = cnt + 4'd1;
            if (cnt + 4'd1 == DS) begin
              state_nxt = ST_PRESENT;
              code_nxt  = key_legend(cand);
              valid_nxt = 1'b1;
            end
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      // Handshake is checked every clock; frames are ignored here, so a
      // coincident frame end is simply dropped.
      ST_PRESENT: begin
        if (key_ready) begin
          valid_nxt = 1'b0;
          cnt_nxt   = '0;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (frame_end) begin
          if (fclass == FR_NONE) begin
            if (cnt + 4'd1 == DS) begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int STC   = 10;
  localparam int DS    = 3;
  localparam int FRAME = 4 * STC;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  col, row, key_code;
  logic        key_valid, multi_key;
  logic        key_ready = 1'b0;
  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] LEG [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                      4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  always #5 clock = ~clock;

  keypad_scanner #(.SCAN_TICK_CYCLES(STC), .DEBOUNCE_SCANS(DS)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .multi_key (multi_key)
  );

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && pressed[4*r+c]) row[r] = 1'b0;
  end

  // ---------------- reference model (frame-level view of the spec) ----------
  int         m_edges, m_streak, m_last, m_rel;
  bit         m_armed, m_pending, m_multi;
  logic [3:0] m_code;

  task automatic model_reset();
    m_edges = 0; m_streak = 0; m_last = 0; m_rel = 0;
    m_armed = 1; m_pending = 0; m_multi = 0; m_code = 4'h0;
  endtask

  // Called at every rising edge with the inputs that edge sees.
  task automatic model_edge();
    int  n, k;
    bit  fe, hs;
    m_edges++;
    fe = (m_edges % FRAME == 0);
    hs = m_pending && key_ready;
    n  = $countones(pressed);
    k  = 0;
    for (int i = 15; i >= 0; i--) if (pressed[i]) k = i;
    if (fe) m_multi = (n >= 2);
    if (hs) begin
      m_pending = 0; m_armed = 0; m_rel = 0;
    end else if (fe && !m_pending) begin
      if (!m_armed) begin
        m_rel = (n == 0) ? m_rel + 1 : 0;
        if (m_rel == DS) begin m_armed = 1; m_rel = 0; end
      end else begin
        if (n == 1 && (m_streak == 0 || k == m_last)) begin
          m_streak++; m_last = k;
        end else m_streak = 0;
        if (m_streak == DS) begin
          m_pending = 1; m_code = LEG[k]; m_streak = 0;
        end
      end
    end
  endtask

  function automatic logic [9:0] expv();
    logic [3:0] ce;
    ce = 4'hF ^ (4'b0001 << ((m_edges / STC) % 4));
    return {ce, m_pending, m_pending ? m_code : 4'h0, m_multi};
  endfunction

  function automatic logic [9:0] obsv();
    return {col, key_valid, key_valid ? key_code : 4'h0, multi_key};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; key_ready = 1'b0; pressed = '0;
    repeat (3) @(negedge clock);
    model_reset();
    reset_n = 1'b1;
  endtask

  function automatic logic [15:0] kb(input int idx);
    return 16'(1) << idx;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; key_ready = 1'b0; pressed = '0;
    @(negedge clock);
    checks++;
    if ({col, key_valid, key_code, multi_key} !== {4'b1110, 1'b0, 4'h0, 1'b0}) begin
      errors++; $display("FAIL reset_values: got %b expected %b", {col, key_valid, key_code, multi_key}, 10'b1110_0_0000_0);
    end
    @(negedge clock);
    model_reset();
    reset_n = 1'b1;
    repeat (2 * FRAME) begin
      tick();
      checks++;
      if (obsv() !== expv()) begin errors++; $display("FAIL reset_scan edge %0d: got %b expected %b", m_edges, obsv(), expv()); end
      if (m_edges == STC || m_edges == FRAME) begin
        checks++;
        if (col !== ((m_edges == STC) ? 4'b1101 : 4'b1110)) begin
          errors++; $display("FAIL col_step edge %0d: got %b", m_edges, col);
        end
      end
    end
  endtask

  task automatic test_single_press();
    int width = 0, rise = -1;
    do_reset();
    pressed = kb(5); key_ready = 1'b1;
    repeat (10 * FRAME) begin
      tick();
      checks++;
      if (obsv() !== expv()) begin errors++; $display("FAIL single_press edge %0d: got %b expected %b", m_edges, obsv(), expv()); end
      if (key_valid) begin width++; if (rise < 0) rise = m_edges; end
    end
    checks++;
    if (width != 1 || rise != 3 * FRAME) begin
      errors++; $display("FAIL single_press_pulse: width %0d rise %0d, expected width 1 rise %0d", width, rise, 3 * FRAME);
    end
  endtask

  task automatic test_short_press();
    int width = 0, rise = -1;
    do_reset();
    pressed = kb(10); key_ready = 1'b1;
    repeat (10 * FRAME) begin
      tick();
      if (m_edges == 2 * FRAME) pressed = '0;
      if (m_edges == 6 * FRAME) pressed = kb(10);
      checks++;
      if (obsv() !== expv()) begin errors++; $display("FAIL short_press edge %0d: got %b expected %b", m_edges, obsv(), expv()); end
      if (key_valid) begin width++; if (rise < 0) rise = m_edges; end
    end
    checks++;
    if (width != 1 || rise != 9 * FRAME) begin
      errors++; $display("FAIL short_press_pulse: width %0d rise %0d, expected width 1 rise %0d", width, rise, 9 * FRAME);
    end
  endtask

  task automatic test_held_no_ready();
    int widths[$];
    bit prev = 0;
    do_reset();
    pressed = kb(11);
    repeat (1640) begin
      tick();
      if (m_edges == 4 * FRAME) pressed = '0;
      if (m_edges == 3 * FRAME + 999) key_ready = 1'b1;   // handshake lands on a frame end
      if (m_edges == 30 * FRAME) pressed = kb(12);        // only 2 empty frames before
      if (m_edges == 34 * FRAME) pressed = '0;
      if (m_edges == 37 * FRAME) pressed = kb(12);        // after 3 empty frames
      checks++;
      if (obsv() !== expv()) begin errors++; $display("FAIL held_no_ready edge %0d: got %b expected %b", m_edges, obsv(), expv()); end
      if (key_valid && !prev) widths.push_back(1);
      else if (key_valid) widths[widths.size()-1]++;
      prev = key_valid;
    end
    checks++;
    if (widths.size() != 2 || widths[0] != 1000 || widths[1] != 1) begin
      errors++;
      $display("FAIL held_no_ready_pulses: count %0d first %0d, expected 2 pulses of 1000 and 1",
               widths.size(), (widths.size() > 0) ? widths[0] : -1);
    end
  endtask

  task automatic test_multi();
    int width = 0, rise = -1;
    do_reset();
    pressed = kb(0) | kb(1); key_ready = 1'b1;
    repeat (8 * FRAME) begin
      tick();
      if (m_edges == 3 * FRAME) pressed = kb(0);
      checks++;
      if (obsv() !== expv()) begin errors++; $display("FAIL multi edge %0d: got %b expected %b", m_edges, obsv(), expv()); end
      if (m_edges == FRAME || m_edges == 4 * FRAME) begin
        checks++;
        if (multi_key !== (m_edges == FRAME)) begin errors++; $display("FAIL multi_flag edge %0d: got %b", m_edges, multi_key); end
      end
      if (key_valid) begin width++; if (rise < 0) rise = m_edges; end
    end
    checks++;
    if (width != 1 || rise != 6 * FRAME) begin
      errors++; $display("FAIL multi_pulse: width %0d rise %0d, expected width 1 rise %0d", width, rise, 6 * FRAME);
    end
  endtask

  task automatic test_reset_in_present();
    int width = 0, rise = -1;
    do_reset();
    pressed = kb(8);
    repeat (3 * FRAME + 10) begin
      tick();
      checks++;
      if (obsv() !== expv()) begin errors++; $display("FAIL pre_reset edge %0d: got %b expected %b", m_edges, obsv(), expv()); end
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({key_valid, col} !== {1'b0, 4'b1110}) begin
      errors++; $display("FAIL async_reset: got valid %b col %b, expected 0 1110", key_valid, col);
    end
    @(negedge clock);
    model_reset();
    reset_n = 1'b1; key_ready = 1'b1;
    repeat (5 * FRAME) begin
      tick();
      checks++;
      if (obsv() !== expv()) begin errors++; $display("FAIL post_reset edge %0d: got %b expected %b", m_edges, obsv(), expv()); end
      if (key_valid) begin width++; if (rise < 0) rise = m_edges; end
    end
    checks++;
    if (width != 1 || rise != 3 * FRAME) begin
      errors++; $display("FAIL post_reset_pulse: width %0d rise %0d, expected width 1 rise %0d", width, rise, 3 * FRAME);
    end
  endtask

  task automatic test_random();
    int seg = 0;
    logic [15:0] pat = '0;
    int a;
    do_reset();
    repeat (60 * FRAME) begin
      if (m_edges % FRAME == 0) begin
        if (seg == 0) begin
          seg = $urandom_range(1, 5);
          case ($urandom_range(0, 5))
            0, 1:    pat = '0;
            5: begin
              a   = $urandom_range(0, 15);
              pat = kb(a) | kb((a + $urandom_range(1, 15)) % 16);
            end
            default: pat = kb($urandom_range(0, 15));
          endcase
        end
        pressed = pat;
        seg--;
      end
      key_ready = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (obsv() !== expv()) begin errors++; $display("FAIL random edge %0d: got %b expected %b", m_edges, obsv(), expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_short_press();
    test_held_no_ready();
    test_multi();
    test_reset_in_present();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
